// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch (imem) and load/store (dmem)
// Fixed dmem priority with an imem starvation guard; ARB_STATS_EN adds grant/conflict counters.
module mem_port_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_req,
  input  logic [WIDTH-1:0] imem_addr,
  output logic             imem_gnt,
  output logic             imem_rvalid,
  output logic [WIDTH-1:0] imem_rdata,
  input  logic             dmem_req,
  input  logic             dmem_we,
  input  logic [WIDTH-1:0] dmem_addr,
  input  logic [WIDTH-1:0] dmem_wdata,
  output logic             dmem_gnt,
  output logic             dmem_rvalid,
  output logic [WIDTH-1:0] dmem_rdata,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [31:0]      stat_imem_grants,
  output logic [31:0]      stat_dmem_grants,
  output logic [31:0]      stat_conflicts
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [1:0]    state;
  logic          owner_d;
  logic [WW-1:0] wait_cnt;
  logic          decide;
  logic          pick_d;
  logic          pick_i;

  // dmem wins ties unless imem has already lost MAX_WAIT decisions in a row
  always_comb begin
    decide = (state == S_IDLE) || (state == S_RESP);
    pick_d = decide && dmem_req && !(imem_req && (wait_cnt == WAIT_MAX));
    pick_i = decide && imem_req && !pick_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner_d     <= 1'b0;
      imem_gnt    <= 1'b0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
      dmem_gnt    <= 1'b0;
      dmem_rvalid <= 1'b0;
      dmem_rdata  <= '0;
      mem_ren     <= 1'b0;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      imem_gnt    <= 1'b0;
      dmem_gnt    <= 1'b0;
      imem_rvalid <= 1'b0;
      dmem_rvalid <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          if (pick_d) begin
            state     <= S_ACCESS;
            owner_d   <= 1'b1;
            dmem_gnt  <= 1'b1;
            mem_addr  <= dmem_addr;
            mem_wdata <= dmem_we ? dmem_wdata : '0;
            mem_ren   <= ~dmem_we;
            mem_wen   <= dmem_we;
          end else if (pick_i) begin
            state     <= S_ACCESS;
            owner_d   <= 1'b0;
            imem_gnt  <= 1'b1;
            mem_addr  <= imem_addr;
            mem_wdata <= '0;
            mem_ren   <= 1'b1;
            mem_wen   <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          // memory completed on the mid-cycle negedge; mem_rdata is stable here
          state   <= S_RESP;
          mem_ren <= 1'b0;
          mem_wen <= 1'b0;
          if (owner_d) begin
            dmem_rdata  <= mem_wen ? '0 : mem_rdata;
            dmem_rvalid <= 1'b1;
          end else begin
            imem_rdata  <= mem_rdata;
            imem_rvalid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (pick_i) begin
      wait_cnt <= '0;
    end else if (pick_d && imem_req && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_imem_grants <= '0;
      stat_dmem_grants <= '0;
      stat_conflicts   <= '0;
    end else begin
      if (pick_i) stat_imem_grants <= stat_imem_grants + 32'd1;
      if (pick_d) stat_dmem_grants <= stat_dmem_grants + 32'd1;
      if (decide && imem_req && dmem_req) stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`else
  assign stat_imem_grants = '0;
  assign stat_dmem_grants = '0;
  assign stat_conflicts   = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with negedge memory model
module tb_mem_port_arbiter;

  localparam int MW = 4;
`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] stat_imem_grants, stat_dmem_grants, stat_conflicts;
  logic [229:0] all_out;

  int total = 0;
  int bad = 0;

  mem_port_arbiter #(.WIDTH(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stat_imem_grants(stat_imem_grants), .stat_dmem_grants(stat_dmem_grants),
    .stat_conflicts(stat_conflicts)
  );

  always #5 clk = ~clk;

  assign all_out = {imem_gnt, imem_rvalid, imem_rdata, dmem_gnt, dmem_rvalid, dmem_rdata,
                    mem_ren, mem_wen, mem_addr, mem_wdata,
                    stat_imem_grants, stat_dmem_grants, stat_conflicts};

  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(i) * 32'h0000_0101);
  endfunction

  // word memory acting on the negedge; contents loaded on the first negedge
  logic [31:0] mem [0:255];
  logic mem_ready = 1'b0;
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else begin
      if (mem_wen) mem[mem_addr[9:2]] <= mem_wdata;
      if (mem_ren) mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_req = 0; imem_addr = 0; dmem_req = 0; dmem_we = 0; dmem_addr = 0; dmem_wdata = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    #12;
    total++; if (all_out !== '0) begin bad++; $display("FAIL reset_outputs got=%0h exp=0", all_out); end
    tick();
    rst_n = 1;
  endtask

  task automatic test_fetch();
    do_reset();
    imem_req = 1; imem_addr = 32'h10;
    tick();
    total++; if ({imem_gnt, mem_ren, mem_wen, imem_rvalid} !== 4'b1100) begin bad++; $display("FAIL fetch_c1 got=%b exp=1100", {imem_gnt, mem_ren, mem_wen, imem_rvalid}); end
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL fetch_addr got=%h exp=00000010", mem_addr); end
    imem_req = 0;
    tick();
    total++; if ({imem_gnt, imem_rvalid} !== 2'b01) begin bad++; $display("FAIL fetch_c2 got=%b exp=01", {imem_gnt, imem_rvalid}); end
    total++; if (imem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata got=%h exp=deadbeef", imem_rdata); end
    tick();
    total++; if (imem_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_c3 got=%b exp=0", imem_rvalid); end
  endtask

  task automatic test_store_then_fetch();
    int wen_cnt = 0;
    do_reset();
    dmem_req = 1; dmem_we = 1; dmem_addr = 32'h100; dmem_wdata = 32'h12345678;
    tick();
    wen_cnt += int'(mem_wen);
    total++; if ({dmem_gnt, mem_wen, mem_ren} !== 3'b110) begin bad++; $display("FAIL store_c1 got=%b exp=110", {dmem_gnt, mem_wen, mem_ren}); end
    total++; if (mem_wdata !== 32'h12345678) begin bad++; $display("FAIL store_wdata got=%h exp=12345678", mem_wdata); end
    dmem_req = 0; imem_req = 1; imem_addr = 32'h100;
    tick();
    wen_cnt += int'(mem_wen);
    total++; if ({dmem_rvalid, dmem_rdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL store_resp got=%b/%h exp=1/00000000", dmem_rvalid, dmem_rdata); end
    tick();
    wen_cnt += int'(mem_wen);
    total++; if (imem_gnt !== 1'b1) begin bad++; $display("FAIL store_fetch_gnt got=%b exp=1", imem_gnt); end
    imem_req = 0;
    tick();
    wen_cnt += int'(mem_wen);
    total++; if ({imem_rvalid, imem_rdata} !== {1'b1, 32'h12345678}) begin bad++; $display("FAIL store_fetch_data got=%b/%h exp=1/12345678", imem_rvalid, imem_rdata); end
    total++; if (wen_cnt != 1) begin bad++; $display("FAIL store_wen_pulse got=%0d exp=1", wen_cnt); end
  endtask

  task automatic test_conflict();
    do_reset();
    imem_req = 1; imem_addr = 32'h8; dmem_req = 1; dmem_we = 0; dmem_addr = 32'hC;
    tick();
    total++; if ({dmem_gnt, imem_gnt} !== 2'b10) begin bad++; $display("FAIL conf_c1 got=%b exp=10", {dmem_gnt, imem_gnt}); end
    dmem_req = 0;
    tick();
    total++; if ({dmem_rvalid, dmem_rdata} !== {1'b1, init_word(3)}) begin bad++; $display("FAIL conf_c2 got=%b/%h exp=1/%h", dmem_rvalid, dmem_rdata, init_word(3)); end
    tick();
    total++; if ({dmem_gnt, imem_gnt} !== 2'b01) begin bad++; $display("FAIL conf_c3 got=%b exp=01", {dmem_gnt, imem_gnt}); end
    imem_req = 0;
    tick();
    total++; if ({imem_rvalid, imem_rdata} !== {1'b1, init_word(2)}) begin bad++; $display("FAIL conf_c4 got=%b/%h exp=1/%h", imem_rvalid, imem_rdata, init_word(2)); end
    total++; if ({stat_imem_grants, stat_dmem_grants, stat_conflicts} !== (STATS ? {32'd1, 32'd1, 32'd1} : 96'd0))
      begin bad++; $display("FAIL conf_stats got=%0d/%0d/%0d stats_en=%0b", stat_imem_grants, stat_dmem_grants, stat_conflicts, STATS); end
  endtask

  task automatic test_starvation();
    int n = 0;
    do_reset();
    imem_req = 1; imem_addr = 32'h4; dmem_req = 1; dmem_we = 0; dmem_addr = 32'h0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      tick();
      if (imem_gnt || dmem_gnt) begin
        total++;
        if ({imem_gnt, dmem_gnt} !== ((n % (MW + 1) == MW) ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL starve_grant n=%0d got=%b", n, {imem_gnt, dmem_gnt});
        end
        n++;
      end
    end
    total++; if (n != 10) begin bad++; $display("FAIL starve_count got=%0d exp=10", n); end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    imem_req = 1; imem_addr = 32'h10;
    tick();
    total++; if (imem_gnt !== 1'b1) begin bad++; $display("FAIL arst_gnt got=%b exp=1", imem_gnt); end
    #2 rst_n = 0;
    #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL arst_outputs got=%0h exp=0", all_out); end
    clear_inputs();
    tick();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if ({imem_rvalid, dmem_rvalid} !== 2'b00) begin bad++; $display("FAIL arst_no_rvalid c=%0d got=%b exp=00", c, {imem_rvalid, dmem_rvalid}); end
    end
    dmem_req = 1; dmem_we = 0; dmem_addr = 32'h20;
    tick();
    total++; if (dmem_gnt !== 1'b1) begin bad++; $display("FAIL arst_new_gnt got=%b exp=1", dmem_gnt); end
    dmem_req = 0;
    tick();
    total++; if ({dmem_rvalid, dmem_rdata} !== {1'b1, init_word(8)}) begin bad++; $display("FAIL arst_new_data got=%b/%h exp=1/%h", dmem_rvalid, dmem_rdata, init_word(8)); end
  endtask

  // Reference: port free 2 cycles after a grant; winner by priority + loss count; rvalid 1 cycle after grant
  task automatic test_random();
    logic [31:0] ref_mem [0:15];
    logic [31:0] exp_ir = 0, exp_dr = 0, pend_data = 0, exp_addr = 0, exp_wd = 0;
    logic last_d = 0, eg_i, eg_d, ev_i, ev_d, exp_ren, exp_wen;
    int losses = 0, last_g = -10, gi = 0, gd = 0, cf = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    do_reset();
    for (int k = 0; k < 400; k++) begin
      tick();
      eg_i = 0; eg_d = 0; ev_i = 0; ev_d = 0;
      if (last_g == k - 1) begin
        if (last_d) begin ev_d = 1; exp_dr = pend_data; end
        else begin ev_i = 1; exp_ir = pend_data; end
      end
      if (k - last_g >= 2) begin
        if (imem_req && dmem_req) cf++;
        if (dmem_req && !(imem_req && losses == MW)) begin
          eg_d = 1;
          if (imem_req && losses < MW) losses++;
        end else if (imem_req) begin
          eg_i = 1; losses = 0;
        end
      end
      exp_ren = eg_i || (eg_d && !dmem_we);
      exp_wen = eg_d && dmem_we;
      if (eg_d) begin
        gd++; last_g = k; last_d = 1; exp_addr = dmem_addr;
        exp_wd = dmem_we ? dmem_wdata : 32'h0;
        pend_data = dmem_we ? 32'h0 : ref_mem[dmem_addr[5:2]];
        if (dmem_we) ref_mem[dmem_addr[5:2]] = dmem_wdata;
      end
      if (eg_i) begin
        gi++; last_g = k; last_d = 0; exp_addr = imem_addr; exp_wd = 0;
        pend_data = ref_mem[imem_addr[5:2]];
      end
      total++; if ({imem_gnt, dmem_gnt} !== {eg_i, eg_d}) begin bad++; $display("FAIL rnd_gnt k=%0d got=%b exp=%b", k, {imem_gnt, dmem_gnt}, {eg_i, eg_d}); end
      total++; if ({imem_rvalid, dmem_rvalid} !== {ev_i, ev_d}) begin bad++; $display("FAIL rnd_rvalid k=%0d got=%b exp=%b", k, {imem_rvalid, dmem_rvalid}, {ev_i, ev_d}); end
      total++; if ({imem_rdata, dmem_rdata} !== {exp_ir, exp_dr}) begin bad++; $display("FAIL rnd_rdata k=%0d got=%h/%h exp=%h/%h", k, imem_rdata, dmem_rdata, exp_ir, exp_dr); end
      total++; if ({mem_ren, mem_wen} !== {exp_ren, exp_wen}) begin bad++; $display("FAIL rnd_renwen k=%0d got=%b exp=%b", k, {mem_ren, mem_wen}, {exp_ren, exp_wen}); end
      if (eg_i || eg_d) begin
        total++; if ({mem_addr, mem_wdata} !== {exp_addr, exp_wd}) begin bad++; $display("FAIL rnd_addr k=%0d got=%h/%h exp=%h/%h", k, mem_addr, mem_wdata, exp_addr, exp_wd); end
      end
      if (eg_i) imem_req = 0;
      if (eg_d) dmem_req = 0;
      if (!imem_req && $urandom_range(0, 2) != 0) begin
        imem_req = 1; imem_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!dmem_req && $urandom_range(0, 2) != 0) begin
        dmem_req = 1; dmem_we = 1'($urandom_range(0, 1));
        dmem_addr = 32'($urandom_range(0, 15)) << 2; dmem_wdata = $urandom;
      end
    end
    total++; if ({stat_imem_grants, stat_dmem_grants, stat_conflicts} !== (STATS ? {32'(gi), 32'(gd), 32'(cf)} : 96'd0))
      begin bad++; $display("FAIL rnd_stats got=%0d/%0d/%0d exp=%0d/%0d/%0d stats_en=%0b", stat_imem_grants, stat_dmem_grants, stat_conflicts, gi, gd, cf, STATS); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_then_fetch();
    test_conflict();
    test_starvation();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
